// File: rtl/scoped_merge_pkg.sv
// Shared constants and types for the scoped_merge channel merger.
// The default build has no skid buffer; define SCOPED_MERGE_SKID_EN to add one.
package scoped_merge_pkg;
    localparam int DEF_NUM_IN = 4;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_SRC_W  = $clog2(DEF_NUM_IN);

    typedef logic [DEF_SRC_W-1:0] src_t;
endpackage

// File: rtl/scoped_merge_rr_arbiter.sv
// Round-robin arbiter for scoped_merge.
// The search starts just past last_grant and wraps around to it.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);
    always_comb begin
        int c;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        c       = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last_grant) + k) % N;
            if (!gnt_any && req[IW'(c)]) begin
                gnt_any          = 1'b1;
                gnt[IW'(c)]      = 1'b1;
                gnt_idx          = IW'(c);
            end
        end
    end
endmodule

// File: rtl/scoped_merge.sv
// N-to-1 round-robin merger with per-channel bind mask and registered output.
// Define SCOPED_MERGE_SKID_EN to add a skid register that breaks out_ready -> in_ready.
module scoped_merge
    import scoped_merge_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int WIDTH  = DEF_WIDTH,
    localparam int SW    = $clog2(NUM_IN)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       bind_mask,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SW-1:0]           out_src,
    output logic [15:0]             xfer_count
);
    logic [NUM_IN-1:0] eligible;
    logic [NUM_IN-1:0] gnt;
    logic [SW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [SW-1:0]     last_grant;
    logic              load_ok;
    logic              accept;
    logic              drain;
    logic [WIDTH-1:0]  word;

    assign eligible = in_valid & bind_mask;
    assign drain    = out_valid & out_ready;

    rr_arbiter #(.N(NUM_IN), .IW(SW)) u_arb (
        .req        (eligible),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

`ifdef SCOPED_MERGE_SKID_EN
    logic             skid_full;
    logic [WIDTH-1:0] skid_data;
    logic [SW-1:0]    skid_src;
    assign load_ok = !skid_full;
`else
    assign load_ok = !out_valid | out_ready;
`endif

    // rst_n gates the handshake so nothing is accepted while reset is held
    assign accept   = rst_n & gnt_any & load_ok;
    assign in_ready = gnt & {NUM_IN{accept}};
    assign word     = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SW'(NUM_IN - 1);
            xfer_count <= '0;
        end else begin
            if (accept) last_grant <= gnt_idx;
            if (drain)  xfer_count <= xfer_count + 16'd1;
        end
    end

`ifdef SCOPED_MERGE_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
            skid_src  <= '0;
        end else if (!out_valid || drain) begin
            // skid is older than anything arriving now, so it refills first
            if (skid_full) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                out_src   <= skid_src;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= word;
                out_src   <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
            skid_data <= word;
            skid_src  <= gnt_idx;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_src   <= gnt_idx;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_scoped_merge.sv
// Self-checking bench for scoped_merge: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_scoped_merge;
    import scoped_merge_pkg::*;

    localparam int N = 4;
    localparam int W = 8;
`ifdef SCOPED_MERGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   bind_mask, in_valid, in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_data;
    src_t           out_src;
    logic [15:0]    xfer_count;

    always #5 clk = ~clk;

    scoped_merge #(.NUM_IN(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bind_mask  (bind_mask),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .xfer_count (xfer_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // reference model: words held by the DUT are a FIFO of depth 1 (2 with skid)
    typedef struct { logic [W-1:0] data; logic [1:0] src; } word_t;
    word_t       q[$];
    int          m_last;
    logic [15:0] m_xfer;
    bit          m_acc, m_drain;
    word_t       m_word;

    task automatic model_reset();
        q.delete();
        m_last = N - 1;
        m_xfer = '0;
    endtask

    task automatic model_check(string tag);
        logic [N-1:0] elig;
        logic [N-1:0] exp_rdy;
        int g;
        bit ok;
        elig = bind_mask & in_valid;
        g = -1;
        for (int c = m_last + 1; c < N; c++) if (g < 0 && elig[c]) g = c;
        for (int c = 0; c <= m_last; c++) if (g < 0 && elig[c]) g = c;
        ok = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
        m_acc = (g >= 0) && ok;
        exp_rdy = m_acc ? (4'b0001 << g) : 4'b0000;
        chk({tag, ".in_ready"}, in_ready, exp_rdy);
        chk({tag, ".out_valid"}, out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk({tag, ".out_data"}, out_data, q[0].data);
            chk({tag, ".out_src"}, out_src, q[0].src);
        end
        chk({tag, ".xfer_count"}, xfer_count, m_xfer);
        m_drain = (q.size() > 0) && out_ready;
        if (m_acc) begin
            m_word.data = in_data[g*W +: W];
            m_word.src  = 2'(g);
        end
    endtask

    task automatic model_update();
        if (m_drain) begin
            void'(q.pop_front());
            m_xfer = m_xfer + 16'd1;
        end
        if (m_acc) begin
            q.push_back(m_word);
            m_last = int'(m_word.src);
        end
    endtask

    // drives one cycle: inputs set after an edge, checked, then the next edge
    task automatic step(input string tag, input logic [N-1:0] m, input logic [N-1:0] v,
                        input logic ordy, input logic [N*W-1:0] d,
                        output logic [N-1:0] rdy, output logic ov,
                        output logic [W-1:0] od, output logic [1:0] os);
        bind_mask = m;
        in_valid  = v;
        out_ready = ordy;
        in_data   = d;
        #1;
        model_check(tag);
        rdy = in_ready;
        @(posedge clk);
        model_update();
        #1;
        ov = out_valid;
        od = out_data;
        os = out_src;
    endtask

    task automatic do_reset(input string tag);
        bind_mask = '1;
        in_valid  = '1;
        out_ready = 1'b1;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        rst_n     = 1'b0;
        #1;
        chk({tag, ".rst.out_valid"}, out_valid, 0);
        chk({tag, ".rst.in_ready"}, in_ready, 0);
        chk({tag, ".rst.out_data"}, out_data, 0);
        chk({tag, ".rst.out_src"}, out_src, 0);
        chk({tag, ".rst.xfer_count"}, xfer_count, 0);
        @(posedge clk);
        #1;
        chk({tag, ".rst.in_ready_edge"}, in_ready, 0);
        chk({tag, ".rst.out_valid_edge"}, out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] valid;
        logic         ordy;
        logic [N-1:0] rdy;
        logic         ov;
        logic [W-1:0] od;
        logic [1:0]   os;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]   rdy;
        logic           ov;
        logic [W-1:0]   od;
        logic [1:0]     os;
        logic [N*W-1:0] d;
        int accepts, sent, delivered;

        d = {8'h44, 8'h33, 8'h22, 8'h11};
        tbl[0] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[1] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[2] = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[3] = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[4] = '{4'hA, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[5] = '{4'hA, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[6] = '{4'hA, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[7] = '{4'hA, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[8] = '{4'hA, 4'h5, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        tbl[9] = '{4'hA, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};

        // vector table: in-order sweep, then masked alternation and idle hold
        do_reset("tbl");
        for (int i = 0; i < 10; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].valid, tbl[i].ordy, d, rdy, ov, od, os);
            chk($sformatf("tbl%0d.rdy", i), rdy, tbl[i].rdy);
            chk($sformatf("tbl%0d.ov", i), ov, tbl[i].ov);
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d.od", i), od, tbl[i].od);
                chk($sformatf("tbl%0d.os", i), os, tbl[i].os);
            end
        end

        // output stall holding 0x22 for five cycles
        do_reset("stall");
        step("stall.load", 4'hF, 4'b0010, 1'b1, d, rdy, ov, od, os);
        chk("stall.load.od", od, 8'h22);
        accepts = 0;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("stall%0d", i), 4'hF, 4'b0010, 1'b0, d, rdy, ov, od, os);
            if (rdy != 0) accepts++;
            chk($sformatf("stall%0d.ov", i), ov, 1);
            chk($sformatf("stall%0d.od", i), od, 8'h22);
            chk($sformatf("stall%0d.os", i), os, 1);
        end
        chk("stall.accepts", accepts, SKID ? 1 : 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall.drain%0d", i), 4'hF, 4'b0000, 1'b1, d, rdy, ov, od, os);

        // asynchronous reset mid-stream, then channel 0 must win first
        do_reset("mid");
        step("mid.a", 4'hF, 4'hF, 1'b1, d, rdy, ov, od, os);
        step("mid.b", 4'hF, 4'hF, 1'b1, d, rdy, ov, od, os);
        chk("mid.pre_rst_ov", out_valid, 1);
        #2;
        do_reset("mid2");
        step("mid.first", 4'hF, 4'hF, 1'b1, d, rdy, ov, od, os);
        chk("mid.first.rdy", rdy, 4'b0001);
        chk("mid.first.os", os, 0);

        // single channel toggling valid: nothing lost or duplicated
        do_reset("tog");
        sent = 0;
        delivered = 0;
        for (int i = 0; i < 20; i++) begin
            d = {8'h44, 8'(8'hA0 + i), 8'h22, 8'h11};
            step($sformatf("tog%0d", i), 4'hF, (i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b1, d, rdy, ov, od, os);
            if (i % 2 == 0) sent++;
            if (ov) begin
                delivered++;
                chk($sformatf("tog%0d.os", i), os, 2);
                chk($sformatf("tog%0d.od", i), od, 8'hA0 + i);
            end
        end
        chk("tog.count", delivered, sent);

        // randomized traffic against the model
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) != 0), 32'($urandom), rdy, ov, od, os);
        end

        // xfer_count wrap: first edge loads, each later edge moves one word out
        do_reset("wrap");
        repeat (65536) @(posedge clk);
        #1;
        chk("wrap.ffff", xfer_count, 16'hFFFF);
        chk("wrap.ov", out_valid, 1);
        @(posedge clk);
        #1;
        chk("wrap.zero", xfer_count, 16'h0000);
        do_reset("end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
